uart_rx_buffered: RTL and testbench

- UART receive front-end of the SMU_RV32I_System serial path, sitting directly downstream of the UART_RXD pin.
- Deserialises 8N1 frames from an asynchronous serial line.
- Validates start and stop bits, then buffers received bytes in a small FIFO.
- Presents bytes to the CPU-side MMIO/UART controller over a ready/valid interface, so back-to-back host characters are not lost while software polls.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/sync_fifo.sv | 59 +++++
 rtl/uart_rx_buffered.sv | 146 ++++++++++++++
 tb/tb_uart_rx_buffered.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, data width and baud timing helper.
// Imported by the RX front-end and reusable by the future TX path.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  typedef struct packed {
    int unsigned symbol_edge_time;
    int unsigned sample_time;
  } baud_timing_t;

  // Cycles per bit and the mid-bit offset used to centre the first sample.
  function automatic baud_timing_t calc_baud_timing(input int unsigned clock_freq,
                                                    input int unsigned baud_rate);
    baud_timing_t t;
    t.symbol_edge_time = clock_freq / baud_rate;
    t.sample_time      = t.symbol_edge_time / 2;
    return t;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  output logic                       full,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == DEPTH_CNT);
  assign pop_data = mem[rd_ptr];
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);

  // NOTE: storage has no reset; occupancy alone decides what is valid, so
  // stale contents can never leak out as data.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  a_count_bounded: assert property (@(posedge clk) disable iff (rst) count <= DEPTH_CNT);

endmodule

// File: rtl/uart_rx_buffered.sv
// 8N1 UART receiver: synchroniser, mid-bit sampling FSM and a byte FIFO
// presented to the consumer over ready/valid.
module uart_rx_buffered
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         serial_in,
  output logic [UART_DATA_W-1:0]       data_out,
  output logic                         data_out_valid,
  input  logic                         data_out_ready,
  output logic                         frame_err,
  output logic                         overrun,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

  localparam baud_timing_t TIMING = calc_baud_timing(CLOCK_FREQ, BAUD_RATE);
  localparam int SYMBOL_EDGE_TIME = int'(TIMING.symbol_edge_time);
  localparam int SAMPLE_TIME      = int'(TIMING.sample_time);
  localparam int CNT_W            = $clog2(SYMBOL_EDGE_TIME);
  localparam int BIT_W            = $clog2(UART_DATA_W);

  localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_TIME - 1);
  localparam logic [CNT_W-1:0] EDGE_LAST   = CNT_W'(SYMBOL_EDGE_TIME - 1);
  localparam logic [BIT_W-1:0] LAST_BIT    = BIT_W'(UART_DATA_W - 1);

  logic rx_meta;
  logic rx_s;

  rx_state_t              state, state_n;
  logic [CNT_W-1:0]       clk_cnt, clk_cnt_n;
  logic [BIT_W-1:0]       bit_idx, bit_idx_n;
  logic [UART_DATA_W-1:0] shift_reg, shift_n;
  logic                   byte_done;

  logic fifo_full;
  logic fifo_empty;
  logic fifo_pop;

  // Both stages reset high so reset never fabricates a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= serial_in;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      clk_cnt   <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
    end else begin
      state     <= state_n;
      clk_cnt   <= clk_cnt_n;
      bit_idx   <= bit_idx_n;
      shift_reg <= shift_n;
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case statement can infer a latch.
  always_comb begin
    state_n   = state;
    clk_cnt_n = clk_cnt + 1'b1;
    bit_idx_n = bit_idx;
    shift_n   = shift_reg;
    byte_done = 1'b0;
    frame_err = 1'b0;

    unique case (state)
      IDLE: begin
        clk_cnt_n = '0;
        if (!rx_s) state_n = START;
      end
      START: begin
        if (clk_cnt == SAMPLE_LAST) begin
          clk_cnt_n = '0;
          if (rx_s) begin
            state_n = IDLE;
          end else begin
            state_n   = DATA;
            bit_idx_n = '0;
          end
        end
      end
      DATA: begin
        if (clk_cnt == EDGE_LAST) begin
          clk_cnt_n = '0;
          shift_n   = {rx_s, shift_reg[UART_DATA_W-1:1]};
          bit_idx_n = bit_idx + 1'b1;
          if (bit_idx == LAST_BIT) state_n = STOP;
        end
      end
      STOP: begin
        if (clk_cnt == EDGE_LAST) begin
          clk_cnt_n = '0;
          if (rx_s) begin
            byte_done = 1'b1;
            state_n   = IDLE;
          end else begin
            frame_err = 1'b1;
            state_n   = BREAK;
          end
        end
      end
      BREAK: begin
        // A line held low is a break, not a stream of zero bytes.
        clk_cnt_n = '0;
        if (rx_s) state_n = IDLE;
      end
      default: begin
        clk_cnt_n = '0;
        state_n   = IDLE;
      end
    endcase
  end

  assign data_out_valid = !fifo_empty;
  assign fifo_pop       = data_out_valid && data_out_ready;
  assign overrun        = byte_done && fifo_full && !fifo_pop;

  sync_fifo #(
    .WIDTH (UART_DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (byte_done),
    .push_data (shift_reg),
    .full      (fifo_full),
    .pop       (fifo_pop),
    .pop_data  (data_out),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Self-checking bench for uart_rx_buffered at 50 cycles/bit: a frame-level
// model predicts per-cycle outputs; directed literals pin the model.
module tb_uart_rx_buffered;

  localparam int CLOCK_FREQ = 50_000_000;
  localparam int BAUD_RATE  = 1_000_000;
  localparam int FIFO_DEPTH = 8;
  localparam int BIT_CYC    = CLOCK_FREQ / BAUD_RATE;
  // Falling edge -> 2 sync flops -> IDLE decision, then mid-bit stop sample.
  localparam int STOP_LAT   = 3 + BIT_CYC / 2 + 9 * BIT_CYC - 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       serial_in = 1'b1;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       data_out_ready = 1'b0;
  logic       frame_err;
  logic       overrun;
  logic [3:0] fifo_count;

  uart_rx_buffered #(
    .CLOCK_FREQ (CLOCK_FREQ),
    .BAUD_RATE  (BAUD_RATE),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .serial_in      (serial_in),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .frame_err      (frame_err),
    .overrun        (overrun),
    .fifo_count     (fifo_count)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: each frame lands at a fixed cycle after its falling edge.
  typedef struct {
    int         at_cyc;
    logic [7:0] data;
    bit         stop_ok;
  } frame_ev_t;

  frame_ev_t  evq[$];
  logic [7:0] mq[$];
  bit         model_en  = 1'b0;
  int         ov_seen   = 0;
  int         fe_seen   = 0;
  int         rise_cyc  = -1;
  int         last_fall = 0;
  logic       prev_valid = 1'b0;

  always @(negedge clk) begin
    bit        pop_m;
    bit        push_m;
    bit        fe_m;
    bit        ov_m;
    frame_ev_t ev;
    if (model_en) begin
      pop_m  = (mq.size() != 0) && data_out_ready;
      push_m = 1'b0;
      fe_m   = 1'b0;
      ov_m   = 1'b0;
      if (evq.size() != 0 && evq[0].at_cyc == cyc) begin
        ev = evq.pop_front();
        if (!ev.stop_ok)                             fe_m   = 1'b1;
        else if (mq.size() == FIFO_DEPTH && !pop_m)  ov_m   = 1'b1;
        else                                         push_m = 1'b1;
      end
      check("valid", 32'(data_out_valid), 32'(mq.size() != 0));
      check("count", 32'(fifo_count), 32'(mq.size()));
      if (mq.size() != 0) check("data_out", 32'(data_out), 32'(mq[0]));
      check("frame_err", 32'(frame_err), 32'(fe_m));
      check("overrun", 32'(overrun), 32'(ov_m));
      if (rst) begin
        mq.delete();
        evq.delete();
      end else begin
        if (pop_m)  void'(mq.pop_front());
        if (push_m) mq.push_back(ev.data);
      end
    end
    if (overrun)   ov_seen++;
    if (frame_err) fe_seen++;
    if (data_out_valid && !prev_valid) rise_cyc = cyc;
    prev_valid = data_out_valid;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_bit);
    @(posedge clk); #1;
    serial_in = 1'b0;
    last_fall = cyc;
    evq.push_back('{at_cyc: cyc + STOP_LAT, data: b, stop_ok: stop_bit});
    tick(BIT_CYC);
    for (int i = 0; i < 8; i++) begin
      serial_in = b[i];
      tick(BIT_CYC);
    end
    serial_in = stop_bit;
    tick(BIT_CYC);
  endtask

  task automatic drain_expect(input string name, input logic [7:0] exp);
    @(posedge clk); #1;
    check({name, "_valid"}, 32'(data_out_valid), 32'd1);
    check(name, 32'(data_out), 32'(exp));
    data_out_ready = 1'b1;
    @(posedge clk); #1;
    data_out_ready = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int ov0;
    int fe0;
    int t;

    // Reset state
    tick(3);
    check("rst_valid", 32'(data_out_valid), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    rst = 1'b0;
    tick(1);
    model_en = 1'b1;
    tick(20);

    // Single byte with latency measurement
    send_frame(8'h61, 1'b1);
    lat = rise_cyc - last_fall;
    checks++;
    if (lat < 476 || lat > 480) begin
      failures++;
      $display("FAIL latency: got %0d cycles, required 478 +/- 2", lat);
    end
    check("single_data", 32'(data_out), 32'h61);
    check("single_count", 32'(fifo_count), 32'd1);
    data_out_ready = 1'b1;
    tick(1);
    data_out_ready = 1'b0;
    check("single_pop_valid", 32'(data_out_valid), 32'd0);
    check("single_pop_count", 32'(fifo_count), 32'd0);
    tick(20);

    // Burst of 10 into an 8-deep FIFO
    ov0 = ov_seen;
    for (int i = 0; i < 10; i++) send_frame(8'h61 + 8'(i), 1'b1);
    tick(5);
    check("burst_overruns", 32'(ov_seen - ov0), 32'd2);
    check("burst_count", 32'(fifo_count), 32'd8);
    for (int i = 0; i < 8; i++) drain_expect("burst_drain", 8'h61 + 8'(i));
    tick(1);
    check("burst_empty", 32'(data_out_valid), 32'd0);
    tick(20);

    // Framing error followed by a held-low break
    fe0 = fe_seen;
    send_frame(8'h55, 1'b0);
    tick(3 * BIT_CYC);
    serial_in = 1'b1;
    tick(20);
    send_frame(8'h41, 1'b1);
    tick(5);
    check("ferr_pulses", 32'(fe_seen - fe0), 32'd1);
    drain_expect("ferr_next", 8'h41);
    tick(20);

    // Glitch rejection
    fe0 = fe_seen;
    @(posedge clk); #1;
    serial_in = 1'b0;
    tick(10);
    serial_in = 1'b1;
    tick(60);
    check("glitch_valid", 32'(data_out_valid), 32'd0);
    check("glitch_ferr", 32'(fe_seen - fe0), 32'd0);
    send_frame(8'hA5, 1'b1);
    drain_expect("glitch_next", 8'hA5);
    tick(20);

    // Full FIFO with pop on the exact stop-sample cycle of the 9th byte
    for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), 1'b1);
    ov0 = ov_seen;
    fork
      send_frame(8'h18, 1'b1);
      begin
        @(posedge clk); #1;
        t = cyc + STOP_LAT;
        while (cyc < t) begin
          @(posedge clk); #1;
        end
        data_out_ready = 1'b1;
        @(posedge clk); #1;
        data_out_ready = 1'b0;
      end
    join
    tick(5);
    check("full_pp_count", 32'(fifo_count), 32'd8);
    check("full_pp_overrun", 32'(ov_seen - ov0), 32'd0);
    for (int i = 1; i < 9; i++) drain_expect("full_pp_drain", 8'h10 + 8'(i));
    tick(20);

    // Reset during data bit 4 with two bytes buffered
    send_frame(8'h21, 1'b1);
    send_frame(8'h22, 1'b1);
    check("pre_rst_count", 32'(fifo_count), 32'd2);
    fork
      send_frame(8'hF0, 1'b1);
      begin
        @(posedge clk); #1;
        t = cyc + 250;
        while (cyc < t) begin
          @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_mid_valid", 32'(data_out_valid), 32'd0);
        check("rst_mid_count", 32'(fifo_count), 32'd0);
        check("rst_mid_ferr", 32'(frame_err), 32'd0);
      end
    join
    tick(50);
    check("rst_after_valid", 32'(data_out_valid), 32'd0);
    send_frame(8'h33, 1'b1);
    drain_expect("rst_next", 8'h33);
    tick(10);

    model_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
